// File: rtl/fft_pkg.sv
// Shared definitions for the FFT core drivers: default widths, controller states,
// direction encodings and the {imag, real} memory word layout.
package fft_pkg;

    localparam int unsigned DefaultNb       = 18;
    localparam int unsigned DefaultLogDepth = 10;

    localparam logic FFT_DIR_FORWARD = 1'b0;
    localparam logic FFT_DIR_INVERSE = 1'b1;

    typedef enum logic [2:0] {
        StLoad,
        StStart,
        StWait,
        StRead,
        StOut
    } state_e;

    // Core memory word: imaginary half in the upper bits.
    typedef struct packed {
        logic signed [DefaultNb-1:0] im;
        logic signed [DefaultNb-1:0] re;
    } cplx_t;

endpackage

// File: rtl/out_saturate.sv
// Narrows a signed core value to the codec sample width.
// Clamps when IFFT_SAT_EN is defined, otherwise keeps the low bits (wraps).
module out_saturate #(
    parameter int unsigned InW  = 18,
    parameter int unsigned OutW = 18
) (
    input  logic [InW-1:0]  din,
    output logic [OutW-1:0] dout
);

`ifdef IFFT_SAT_EN
    // In range iff every bit from the new sign position upward matches.
    logic [InW-OutW:0] top_bits;
    assign top_bits = din[InW-1:OutW-1];

    always_comb begin
        dout = din[OutW-1:0];
        if (!(&top_bits) && (|top_bits)) begin
            dout = din[InW-1] ? {1'b1, {(OutW-1){1'b0}}} : {1'b0, {(OutW-1){1'b1}}};
        end
    end
`else
    logic unused_din;
    assign unused_din = ^din;
    assign dout       = din[OutW-1:0];
`endif

endmodule

// File: rtl/ifft_playback_driver.sv
// Loads a spectrum frame into the shared FFT core, runs it inverse, and streams
// back the real part one sample at a time. Output narrowing honours IFFT_SAT_EN.
module ifft_playback_driver
    import fft_pkg::*;
#(
    parameter int unsigned Nb        = DefaultNb,
    parameter int unsigned LOG_DEPTH = DefaultLogDepth,
    parameter int unsigned OUT_W     = DefaultNb
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [Nb-1:0]        bin_real,
    input  logic [Nb-1:0]        bin_imag,
    input  logic                 bin_valid,
    output logic                 bin_ready,
    output logic [OUT_W-1:0]     sample_out,
    output logic                 sample_valid,
    input  logic                 sample_ready,
    output logic                 fft_start,
    input  logic                 fft_done,
    output logic                 fft_direction,
    output logic [3:0]           fft_log_depth,
    output logic                 fft_real_mode,
    output logic [LOG_DEPTH-1:0] fft_address,
    output logic                 fft_write_enable,
    output logic [2*Nb-1:0]      fft_write_data,
    output logic                 fft_read_enable,
    input  logic                 fft_read_valid,
    input  logic [2*Nb-1:0]      fft_read_data,
    output logic                 frame_done
);

    localparam logic [LOG_DEPTH-1:0] LastAddr = {LOG_DEPTH{1'b1}};

    state_e               state_q, state_d;
    logic [LOG_DEPTH-1:0] addr_q, addr_d;
    logic [LOG_DEPTH-1:0] wr_addr_q;
    logic                 wr_en_q;
    logic [2*Nb-1:0]      wr_data_q;
    logic [OUT_W-1:0]     sample_q, sample_d;
    logic [OUT_W-1:0]     sat_value;
    logic                 frame_done_q, frame_done_d;
    logic                 bin_accept;
    logic                 unused_imag;

    assign bin_accept  = bin_valid && (state_q == StLoad);
    assign unused_imag = ^fft_read_data[2*Nb-1:Nb];

    out_saturate #(
        .InW  (Nb),
        .OutW (OUT_W)
    ) u_out_saturate (
        .din  (fft_read_data[Nb-1:0]),
        .dout (sat_value)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sample_d     = sample_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (bin_valid) begin
                    addr_d = addr_q + LOG_DEPTH'(1);
                    if (addr_q == LastAddr) state_d = StStart;
                end
            end
            StStart: state_d = StWait;
            StWait: begin
                if (fft_done) begin
                    addr_d  = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (fft_read_valid) begin
                    sample_d = sat_value;
                    state_d  = StOut;
                end
            end
            StOut: begin
                if (sample_ready) begin
                    if (addr_q == LastAddr) begin
                        frame_done_d = 1'b1;
                        addr_d       = '0;
                        state_d      = StLoad;
                    end else begin
                        addr_d  = addr_q + LOG_DEPTH'(1);
                        state_d = StRead;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StLoad;
            addr_q       <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            sample_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sample_q     <= sample_d;
            frame_done_q <= frame_done_d;
            wr_en_q      <= bin_accept;
            if (bin_accept) begin
                wr_addr_q <= addr_q;
                wr_data_q <= {bin_imag, bin_real};
            end
        end
    end

    // The write lags acceptance by a cycle, so it carries its own address.
    assign fft_address      = wr_en_q ? wr_addr_q : addr_q;
    assign fft_write_enable = wr_en_q;
    assign fft_write_data   = wr_data_q;
    assign bin_ready        = (state_q == StLoad);
    assign fft_start        = (state_q == StStart);
    assign fft_read_enable  = (state_q == StRead);
    assign sample_valid     = (state_q == StOut);
    assign sample_out       = sample_q;
    assign frame_done       = frame_done_q;
    assign fft_direction    = FFT_DIR_INVERSE;
    assign fft_log_depth    = 4'(LOG_DEPTH);
    assign fft_real_mode    = 1'b0;

endmodule
